fib_seq_stream: RTL

Synthesizable, handshake-driven Fibonacci term generator. It produces the sequence 0, 1, 1, 2, 3, 5, 8, 13, … one term per accepted transfer. It is the upstream source stage feeding the sequence-capture/print block, replacing the simulation-only `initial`-loop computation with a clocked stream. A start pulse requests N terms; the block emits them on a valid/ready port, flags the last one, and pulses done.

---
 rtl/fib_pkg.sv | 16 +
 rtl/fib_adder_ovf.sv | 17 +
 rtl/fib_seq_stream.sv | 108 ++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci stream generator.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_t;

  localparam int FIB_WIDTH_DEF = 8;
  localparam int FIB_CNT_W_DEF = 8;

  localparam int F0 = 0;
  localparam int F1 = 1;

endpackage

// File: rtl/fib_adder_ovf.sv
// WIDTH-bit adder returning the truncated sum and the carry out of the top bit.
module fib_adder_ovf #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o
);

  logic [WIDTH:0] sum_full;

  assign sum_full = {1'b0, a_i} + {1'b0, b_i};
  assign sum_o    = sum_full[WIDTH-1:0];
  assign carry_o  = sum_full[WIDTH];

endmodule

// File: rtl/fib_seq_stream.sv
// Handshake-driven Fibonacci term source. Define FIB_OVF_DETECT_EN to truncate
// the stream before the first term that would not fit in WIDTH bits.
module fib_seq_stream
  import fib_pkg::*;
#(
  parameter int WIDTH = FIB_WIDTH_DEF,
  parameter int CNT_W = FIB_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             done,
  output logic             overflow
);

  fib_state_t       state_q;
  logic [WIDTH-1:0] a_q, b_q, b_d;
  logic [CNT_W-1:0] idx_q, num_q;
  logic             cnt_last, last_w;

`ifdef FIB_OVF_DETECT_EN
  logic bovf_d, bovf_q, ovf_q;
`else
  logic carry_unused;
`endif

  fib_adder_ovf #(.WIDTH(WIDTH)) u_add (
    .a_i     (a_q),
    .b_i     (b_q),
    .sum_o   (b_d),
`ifdef FIB_OVF_DETECT_EN
    .carry_o (bovf_d)
`else
    .carry_o (carry_unused)
`endif
  );

  assign cnt_last = (idx_q == num_q - CNT_W'(1));
`ifdef FIB_OVF_DETECT_EN
  // A wrapped successor means the current term is the last representable one.
  assign last_w   = cnt_last || bovf_q;
  assign overflow = ovf_q;
`else
  assign last_w   = cnt_last;
  assign overflow = 1'b0;
`endif

  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == RUN);
  assign out_data  = a_q;
  assign out_last  = (state_q == RUN) && last_w;
  assign done      = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      idx_q   <= '0;
      num_q   <= '0;
`ifdef FIB_OVF_DETECT_EN
      bovf_q  <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= WIDTH'(F0);
            b_q     <= WIDTH'(F1);
            idx_q   <= '0;
            num_q   <= num_terms;
`ifdef FIB_OVF_DETECT_EN
            bovf_q  <= 1'b0;
            ovf_q   <= 1'b0;
`endif
            state_q <= (num_terms == '0) ? DONE : RUN;
          end
        end
        RUN: begin
          if (out_ready) begin
            a_q   <= b_q;
            b_q   <= b_d;
            idx_q <= idx_q + CNT_W'(1);
`ifdef FIB_OVF_DETECT_EN
            bovf_q <= bovf_d;
`endif
            if (last_w) begin
              state_q <= DONE;
`ifdef FIB_OVF_DETECT_EN
              ovf_q   <= bovf_q && !cnt_last;
`endif
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
